cobertura_motor: RTL and testbench
==================================

# cobertura_motor

Sequential model of the roof-cover actuator and its two limit switches: the plant end of the open/close valve interface. Consumes the open (`A`) and close (`F`) commands produced by the cover controller. Integrates travel over clock cycles. Drives back the open-limit (`Fd`) and closed-limit (`Fe`) switch signals that the controller uses to stop the motor. Used in closed-loop benches and as the actuator stand-in for board demos.

## Interface

- `TRAVEL`, 8: full travel in position steps (closed = 0, open = `TRAVEL`); must be ≥ 2.
- `STEP_DIV`, 4: clock cycles per position step while moving; must be ≥ 1.
- `DEAD_CYCLES`, 3: reversal dead time in cycles. Used only with `COBERTURA_DEADTIME_EN`.
- `PW`: derived, `$clog2(TRAVEL+1)`.

Ports:

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `A` input 1: open command.
- `F` input 1: close command.
- `Fd` output 1: open limit switch, 1 when `pos == TRAVEL`.
- `Fe` output 1: closed limit switch, 1 when `pos == 0`.
- `pos` output PW: current cover position.
- `moving` output 1: 1 in OPEN or CLOSE state.
- `fault` output 1: sticky flag, set by a conflicting command (`A & F`).

## Operation

- States: IDLE, OPEN, CLOSE, DEAD. The DEAD state exists only with the macro defined.
- Reset values: state IDLE, `pos` = 0, prescaler = 0, dead counter = 0, `fault` = 0. Consequently `Fe` = 1, `Fd` = 0, `moving` = 0.
- `Fd`, `Fe` and `moving` are combinational decodes of registered state and `pos`.
- Command rules are evaluated every edge, in this priority order:
  1. `A & F`: the state becomes IDLE, `fault` is set to 1, `pos` is held and the prescaler is cleared. This applies in IDLE, OPEN and CLOSE.
  2. IDLE with `A & ~F` and `pos < TRAVEL`: go to OPEN, prescaler = 0.
  3. IDLE with `F & ~A` and `pos > 0`: go to CLOSE, prescaler = 0.
  4. IDLE with a command into a limit (`A` with `pos == TRAVEL`, or `F` with `pos == 0`): stay IDLE.
- OPEN:
  - `~A & ~F`: go to IDLE and clear the prescaler.
  - `F & ~A`: reversal (see Configuration).
  - Otherwise the prescaler increments. When the prescaler is `STEP_DIV-1`, it wraps to 0 and `pos` increments.
  - If that step makes `pos == TRAVEL`, the next state is IDLE on the same edge.
- CLOSE: mirror of OPEN, with `pos` decrementing and stopping at 0.
- DEAD:
  - Counts `DEAD_CYCLES` edges, ignoring `A` and `F`.
  - Then goes to IDLE. IDLE re-evaluates the commands on the following edge.
- `pos` never leaves the range 0 to `TRAVEL`; no wrap-around.
- `fault` clears only on `rst`. The block continues to obey valid commands while `fault` = 1.

## Timing

- A command accepted in IDLE takes effect at the next edge: the state changes and `moving` rises.
- With the command held, the first `pos` step occurs `STEP_DIV` edges after entering OPEN or CLOSE. Later steps follow every `STEP_DIV` edges.
- A full traverse from 0 to `TRAVEL` with `A` held takes 1 + `TRAVEL`·`STEP_DIV` edges from the first sampled `A`. `Fd` and `moving` = 0 appear after that same edge.
- Dropping a command stops motion at the next edge. A partial prescaler count is discarded.
- `rst` mid-motion returns `pos` to 0 at the next edge, regardless of state. This is a model reset, not a physical travel.

## Configuration

- `COBERTURA_DEADTIME_EN` defined:
  - A reversal request (`F & ~A` in OPEN, or `A & ~F` in CLOSE) moves to DEAD. `moving` = 0 and `pos` is held.
  - After `DEAD_CYCLES` edges the state returns to IDLE.
- `COBERTURA_DEADTIME_EN` undefined:
  - A reversal switches directly from OPEN to CLOSE (or the reverse) at the next edge and clears the prescaler.
  - The DEAD state and dead counter are not synthesized.

## Test plan

Defaults apply (`TRAVEL` = 8, `STEP_DIV` = 4, `DEAD_CYCLES` = 3).

- Reset: `rst` = 1 for 2 edges → `pos` = 0, `Fe` = 1, `Fd` = 0, `moving` = 0, `fault` = 0.
- Full open: `A` = 1 held from IDLE:
  - `moving` = 1 after edge 1.
  - `pos` = 1 after edge 5, `pos` = 8 after edge 33.
  - After edge 33, `Fd` = 1 and `moving` = 0. `pos` stays 8 with `A` still high.
- Conflict: in OPEN at `pos` = 3, drive `A` = `F` = 1 → next edge: IDLE, `fault` = 1, `pos` = 3. Then `F` = 1 alone closes to `pos` = 0, `Fe` = 1, with `fault` still 1.
- Reversal with the macro: OPEN at `pos` = 3, switch to `A` = 0, `F` = 1:
  - Sequence is 3 edges of DEAD (`moving` = 0, `pos` = 3), then IDLE, then CLOSE.
  - `pos` reaches 0 after a further 12 edges. `Fe` = 1.
  - Without the macro: CLOSE is entered at the next edge.
- Limit commands: `F` = 1 at `pos` = 0 for 10 edges → IDLE, `moving` = 0, `pos` = 0.
- Reset mid-move: CLOSE at `pos` = 5, assert `rst` for one edge → `pos` = 0, IDLE, `Fe` = 1, `fault` = 0.

Source files
------------

// File: rtl/cobertura_motor.sv
// cobertura_motor: roof-cover actuator model with open/closed limit switches.
// Define COBERTURA_DEADTIME_EN to insert a DEAD pause on direction reversal.
module cobertura_motor #(
  parameter int TRAVEL = 8,
  parameter int STEP_DIV = 4,
  parameter int DEAD_CYCLES = 3,
  localparam int PW = $clog2(TRAVEL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          A,
  input  logic          F,
  output logic          Fd,
  output logic          Fe,
  output logic [PW-1:0] pos,
  output logic          moving,
  output logic          fault
);
  localparam int SW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  if (TRAVEL < 2 || STEP_DIV < 1 || DEAD_CYCLES < 1) begin : g_bad_params
    $error("cobertura_motor: illegal parameter values");
  end
`ifdef COBERTURA_DEADTIME_EN
  localparam int DW = DEAD_CYCLES > 1 ? $clog2(DEAD_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, OPEN, CLOSE, DEAD} state_t;
  logic [DW-1:0] dcnt, dcnt_n;
`else
  typedef enum logic [1:0] {IDLE, OPEN, CLOSE} state_t;
`endif
  state_t state, state_n;
  logic [PW-1:0] pos_n;
  logic [SW-1:0] psc, psc_n;
  logic fault_n, step, opening, dead_now;
  assign Fd = pos == PW'(TRAVEL);
  assign Fe = pos == '0;
  assign moving = state == OPEN || state == CLOSE;
  assign step = psc == SW'(STEP_DIV - 1);
  assign opening = state == OPEN;
`ifdef COBERTURA_DEADTIME_EN
  assign dead_now = state == DEAD;
`else
  assign dead_now = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pos <= '0;
      psc <= '0;
      fault <= 1'b0;
`ifdef COBERTURA_DEADTIME_EN
      dcnt <= '0;
`endif
    end else begin
      state <= state_n;
      pos <= pos_n;
      psc <= psc_n;
      fault <= fault_n;
`ifdef COBERTURA_DEADTIME_EN
      dcnt <= dcnt_n;
`endif
    end
  end
  // Prescaler (and dead counter) default to zero; only a running count keeps them.
  always_comb begin
    state_n = state;
    pos_n = pos;
    psc_n = '0;
    fault_n = fault;
`ifdef COBERTURA_DEADTIME_EN
    dcnt_n = '0;
`endif
    if (A && F && !dead_now) begin
      state_n = IDLE;
      fault_n = 1'b1;
    end else begin
      case (state)
        IDLE: state_n = A && !F && !Fd ? OPEN : F && !A && !Fe ? CLOSE : IDLE;
        OPEN, CLOSE: begin
          if (!A && !F) state_n = IDLE;
          else if (opening ? F : A) begin
`ifdef COBERTURA_DEADTIME_EN
            state_n = DEAD;
`else
            state_n = opening ? (Fe ? IDLE : CLOSE) : (Fd ? IDLE : OPEN);
`endif
          end else if (step) begin
            pos_n = opening ? pos + PW'(1) : pos - PW'(1);
            if (pos == PW'(opening ? TRAVEL - 1 : 1)) state_n = IDLE;
          end else psc_n = psc + SW'(1);
        end
`ifdef COBERTURA_DEADTIME_EN
        DEAD: begin
          dcnt_n = dcnt + DW'(1);
          if (dcnt == DW'(DEAD_CYCLES - 1)) state_n = IDLE;
        end
`endif
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cobertura_motor.sv
// tb_cobertura_motor: directed plus random check of cobertura_motor against a behavioural model.
module tb_cobertura_motor;
  localparam int TRAVEL = 8;
  localparam int STEP_DIV = 4;
  localparam int DEAD_CYCLES = 3;
  localparam int PW = $clog2(TRAVEL + 1);
  logic clk = 1'b0, rst = 1'b1, A = 1'b0, F = 1'b0;
  logic Fd, Fe, moving, fault;
  logic [PW-1:0] pos;
  int vectors = 0, errors = 0;
  int m_mode = 0, m_pos = 0, m_cnt = 0, m_dead = 0, m_fault = 0;
  cobertura_motor #(.TRAVEL(TRAVEL), .STEP_DIV(STEP_DIV), .DEAD_CYCLES(DEAD_CYCLES)) dut (
    .clk(clk), .rst(rst), .A(A), .F(F), .Fd(Fd), .Fe(Fe), .pos(pos), .moving(moving), .fault(fault)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // mode: 0 stopped, 1 opening, 2 closing, 3 reversal pause; m_cnt counts cycles toward the next step
  task automatic model(input bit a, input bit f, input bit r);
    int want;
    if (r) begin
      m_mode = 0; m_pos = 0; m_cnt = 0; m_dead = 0; m_fault = 0;
      return;
    end
    if (m_mode == 3) begin
      m_dead++;
      if (m_dead == DEAD_CYCLES) m_mode = 0;
      return;
    end
    if (a && f) begin
      m_fault = 1; m_mode = 0; m_cnt = 0;
      return;
    end
    if (m_mode == 0) begin
      m_cnt = 0;
      if (a && m_pos < TRAVEL) m_mode = 1;
      else if (f && m_pos > 0) m_mode = 2;
      return;
    end
    want = a ? 1 : f ? 2 : 0;
    if (want == 0) begin
      m_mode = 0; m_cnt = 0;
      return;
    end
    if (want != m_mode) begin
      m_cnt = 0;
`ifdef COBERTURA_DEADTIME_EN
      m_mode = 3; m_dead = 0;
`else
      m_mode = ((want == 1) ? (m_pos < TRAVEL) : (m_pos > 0)) ? want : 0;
`endif
      return;
    end
    m_cnt++;
    if (m_cnt == STEP_DIV) begin
      m_cnt = 0;
      m_pos += (m_mode == 1) ? 1 : -1;
      if (m_pos == 0 || m_pos == TRAVEL) m_mode = 0;
    end
  endtask
  task automatic cyc(input bit a, input bit f, input bit r);
    @(negedge clk);
    A = a; F = f; rst = r;
    @(posedge clk);
    model(a, f, r);
    #1;
    check("pos", int'(pos), m_pos);
    check("Fd", int'(Fd), int'(m_pos == TRAVEL));
    check("Fe", int'(Fe), int'(m_pos == 0));
    check("moving", int'(moving), int'(m_mode == 1 || m_mode == 2));
    check("fault", int'(fault), m_fault);
  endtask
  task automatic run(input bit a, input bit f, input int n);
    repeat (n) cyc(a, f, 1'b0);
  endtask
  initial begin
    cyc(0, 0, 1); cyc(1, 1, 1);
    check("rst_pos", int'(pos), 0); check("rst_Fe", int'(Fe), 1); check("rst_Fd", int'(Fd), 0);
    check("rst_mv", int'(moving), 0); check("rst_fault", int'(fault), 0);
    cyc(1, 0, 0);
    check("open_mv", int'(moving), 1);
    run(1, 0, 4);
    check("open_pos1", int'(pos), 1);
    run(1, 0, 28);
    check("open_pos8", int'(pos), TRAVEL); check("open_Fd", int'(Fd), 1); check("open_stop", int'(moving), 0);
    run(1, 0, 3);
    check("open_hold", int'(pos), TRAVEL);
    run(0, 1, 33);
    check("close_full", int'(pos), 0);
    run(1, 0, 13);
    check("cf_pos3", int'(pos), 3); check("cf_mv", int'(moving), 1);
    cyc(1, 1, 0);
    check("cf_fault", int'(fault), 1); check("cf_hold", int'(pos), 3); check("cf_idle", int'(moving), 0);
    run(0, 1, 13);
    check("cf_closed", int'(pos), 0); check("cf_Fe", int'(Fe), 1); check("cf_sticky", int'(fault), 1);
    run(0, 1, 10);
    check("lim_mv", int'(moving), 0); check("lim_pos", int'(pos), 0);
    run(1, 0, 13);
    check("rev_pos3", int'(pos), 3);
`ifdef COBERTURA_DEADTIME_EN
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0);
      check("dead_mv", int'(moving), 0); check("dead_pos", int'(pos), 3);
    end
    cyc(0, 1, 0);
    check("dead_idle", int'(moving), 0);
    cyc(0, 1, 0);
    check("dead_close", int'(moving), 1);
`else
    cyc(0, 1, 0);
    check("rev_close", int'(moving), 1); check("rev_hold", int'(pos), 3);
`endif
    run(0, 1, 12);
    check("rev_pos0", int'(pos), 0); check("rev_Fe", int'(Fe), 1);
    run(1, 0, 33);
    run(0, 1, 13);
    check("mid_pos5", int'(pos), 5); check("mid_mv", int'(moving), 1);
    cyc(0, 1, 1);
    check("mid_rst_pos", int'(pos), 0); check("mid_rst_mv", int'(moving), 0);
    check("mid_rst_Fe", int'(Fe), 1); check("mid_rst_fault", int'(fault), 0);
    for (int s = 0; s < 250; s++) begin
      bit a, f;
      a = 1'($urandom_range(0, 1));
      f = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin a = 1'b1; f = 1'b1; end
      if ($urandom_range(0, 24) == 0) cyc(a, f, 1'b1);
      else if ($urandom_range(0, 5) == 0) f = ~a;
      run(a, f, int'($urandom_range(1, 40)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
